bounded_updown_counter: RTL and testbench

Parametrised loadable up/down counter with runtime-programmable bounds, step size, and selectable wrap or saturate behaviour. It generalises the team's fixed 4-bit load/up/down counter with the following additions:
- width, reset value and overflow mode are parameters;
- the step is a port;
- lower and upper limits are ports;
- there are terminal-count, event-pulse and sticky overflow/underflow status outputs.

It is used as a general event, timer and address counter inside datapath and control blocks.

---
 rtl/counter_pkg.sv | 17 +
 rtl/updown_next_calc.sv | 45 ++++
 rtl/bounded_updown_counter.sv | 104 ++++++++++
 tb/tb_bounded_updown_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the bounded up/down counter: overflow-mode encodings
// and the next-value/event record produced by the next-state calculator.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widest counter supported; next_q is zero-extended up to this width.
    localparam int CNT_MAX_W = 32;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] next_q;
        logic                 ovf;
        logic                 udf;
    } next_t;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-value calculator: one step up or down against runtime
// lo/hi limits, flagging overflow/underflow and applying wrap or saturate.
module updown_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic             i_up,
    output next_t            o_res
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_step_nz;
    logic           w_ovf;
    logic           w_udf;
    logic [WIDTH-1:0] w_val;

    // One extra bit keeps the carry on the way up and the sign on the way down.
    assign w_sum     = {1'b0, i_q} + {1'b0, i_step};
    assign w_diff    = {1'b0, i_q} - {1'b0, i_step};
    assign w_step_nz = |i_step;

    assign w_ovf = i_up  && w_step_nz && (w_sum > {1'b0, i_hi});
    assign w_udf = !i_up && w_step_nz && ($signed(w_diff) < $signed({1'b0, i_lo}));

    always_comb begin
        w_val = i_up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
        if (w_ovf) begin
            w_val = (MODE == MODE_SAT) ? i_hi : i_lo;
        end else if (w_udf) begin
            w_val = (MODE == MODE_SAT) ? i_lo : i_hi;
        end
    end

    assign o_res.next_q = CNT_MAX_W'(w_val);
    assign o_res.ovf    = w_ovf;
    assign o_res.udf    = w_udf;

endmodule

// File: rtl/bounded_updown_counter.sv
// Loadable up/down counter with runtime limits and step, wrap or saturate at
// the limits, and registered event pulses plus sticky overflow/underflow flags.
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             countup,
    input  logic             countdown,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             at_hi,
    output logic             at_lo,
    output logic             ovf_pulse,
    output logic             udf_pulse,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf_pulse;
    logic             r_udf_pulse;
    logic             r_ovf_sticky;
    logic             r_udf_sticky;

    next_t            w_res;
    logic             w_count;
    logic             w_ovf_evt;
    logic             w_udf_evt;

    // Up wins when both directions are requested.
    updown_next_calc #(
        .WIDTH (WIDTH),
        .MODE  (SATURATE)
    ) u_next_calc (
        .i_q    (r_q),
        .i_step (step),
        .i_lo   (lo),
        .i_hi   (hi),
        .i_up   (countup),
        .o_res  (w_res)
    );

    generate
        if (WIDTH < CNT_MAX_W) begin : g_ext_check
            always_comb assert (w_res.next_q[CNT_MAX_W-1:WIDTH] == '0);
        end
    endgenerate

    assign w_count   = en && (countup || countdown);
    assign w_ovf_evt = !load && w_count && w_res.ovf;
    assign w_udf_evt = !load && w_count && w_res.udf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= RST_VAL;
            r_ovf_pulse  <= 1'b0;
            r_udf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            if (load) begin
                r_q <= d;
            end else if (w_count) begin
                r_q <= w_res.next_q[WIDTH-1:0];
            end

            r_ovf_pulse <= w_ovf_evt;
            r_udf_pulse <= w_udf_evt;

            // A new event beats a simultaneous clear.
            if (w_ovf_evt) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_ovf_sticky <= 1'b0;
            end

            if (w_udf_evt) begin
                r_udf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_udf_sticky <= 1'b0;
            end
        end
    end

    assign q          = r_q;
    assign at_hi      = (r_q == hi);
    assign at_lo      = (r_q == lo);
    assign ovf_pulse  = r_ovf_pulse;
    assign udf_pulse  = r_udf_pulse;
    assign ovf_sticky = r_ovf_sticky;
    assign udf_sticky = r_udf_sticky;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench: a wrap-mode and a saturate-mode instance share stimulus;
// a vector table drives the wrap instance, hand sequences cover the rest.
module tb_bounded_updown_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, load, countup, countdown, clr_flags;
    logic [W-1:0] d, step, lo, hi;

    logic [W-1:0] qa, qb;
    logic         ahi_a, alo_a, op_a, up_a, os_a, us_a;
    logic         ahi_b, alo_b, op_b, up_b, os_b, us_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bounded_updown_counter #(.WIDTH(W), .RST_VAL(4'd5), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .countup(countup), .countdown(countdown), .step(step),
        .lo(lo), .hi(hi), .clr_flags(clr_flags),
        .q(qa), .at_hi(ahi_a), .at_lo(alo_a), .ovf_pulse(op_a),
        .udf_pulse(up_a), .ovf_sticky(os_a), .udf_sticky(us_a)
    );

    bounded_updown_counter #(.WIDTH(W), .RST_VAL(4'd5), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .countup(countup), .countdown(countdown), .step(step),
        .lo(lo), .hi(hi), .clr_flags(clr_flags),
        .q(qb), .at_hi(ahi_b), .at_lo(alo_b), .ovf_pulse(op_b),
        .udf_pulse(up_b), .ovf_sticky(os_b), .udf_sticky(us_b)
    );

    typedef struct {
        logic         load, en, up, dn, clr;
        logic [W-1:0] d, step;
        logic [W-1:0] eq;
        logic [5:0]   ef;   // {at_hi, at_lo, ovf_pulse, udf_pulse, ovf_sticky, udf_sticky}
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic ld, logic e, logic u, logic dn, logic c,
                                logic [W-1:0] dv, logic [W-1:0] st,
                                logic [W-1:0] eq, logic [5:0] ef);
        vec_t v;
        v.load = ld; v.en = e; v.up = u; v.dn = dn; v.clr = c;
        v.d = dv; v.step = st; v.eq = eq; v.ef = ef;
        return v;
    endfunction

    task automatic check(string name, logic sel_sat, logic [W-1:0] eq, logic [5:0] ef);
        logic [W-1:0] gq;
        logic [5:0]   gf;
        gq = sel_sat ? qb : qa;
        gf = sel_sat ? {ahi_b, alo_b, op_b, up_b, os_b, us_b}
                     : {ahi_a, alo_a, op_a, up_a, os_a, us_a};
        n_vec++;
        if (gq !== eq || gf !== ef) begin
            n_bad++;
            $display("FAIL %s: got q=%0d flags=%b, expected q=%0d flags=%b", name, gq, gf, eq, ef);
        end else begin
            $display("ok   %s: q=%0d flags=%b", name, gq, gf);
        end
    endtask

    task automatic drive(logic ld, logic e, logic u, logic dn, logic c,
                         logic [W-1:0] dv, logic [W-1:0] st);
        @(negedge clk);
        load = ld; en = e; countup = u; countdown = dn; clr_flags = c;
        d = dv; step = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 0; load = 0; countup = 0; countdown = 0; clr_flags = 0;
        d = '0; step = '0; lo = 4'd2; hi = 4'd10;

        //                 ld e  up dn clr d   step  q    {hi,lo,op,up,os,us}
        vecs[0]  = mk(1, 0, 0, 0, 0, 9,  3,   9,  6'b000000);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0,  3,   2,  6'b011010);
        vecs[2]  = mk(0, 1, 1, 0, 0, 0,  3,   5,  6'b000010);
        vecs[3]  = mk(1, 1, 1, 0, 0, 7,  3,   7,  6'b000010);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0,  3,   7,  6'b000010);
        vecs[5]  = mk(0, 1, 1, 1, 0, 0,  1,   8,  6'b000010);
        vecs[6]  = mk(0, 1, 0, 1, 1, 0,  1,   7,  6'b000000);
        vecs[7]  = mk(0, 1, 0, 1, 0, 0,  6,  10,  6'b100101);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0,  0,  10,  6'b100001);
        vecs[9]  = mk(1, 0, 0, 0, 0, 15, 0,  15,  6'b000001);
        vecs[10] = mk(0, 1, 1, 0, 0, 0,  0,  15,  6'b000001);
        vecs[11] = mk(0, 1, 1, 0, 0, 0,  1,   2,  6'b011011);
        vecs[12] = mk(0, 1, 1, 0, 1, 0,  8,  10,  6'b100000);
        vecs[13] = mk(0, 1, 1, 0, 1, 0,  1,   2,  6'b011010);
        vecs[14] = mk(0, 0, 0, 0, 1, 0,  0,   2,  6'b010000);
        vecs[15] = mk(1, 0, 0, 0, 0, 3,  0,   3,  6'b000000);
        vecs[16] = mk(0, 1, 0, 1, 0, 0,  5,  10,  6'b100101);
        vecs[17] = mk(0, 1, 0, 1, 0, 0,  8,   2,  6'b010001);

        #12;
        check("reset_wrap", 1'b0, 4'd5, 6'b000000);
        check("reset_sat",  1'b1, 4'd5, 6'b000000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].dn, vecs[i].clr,
                  vecs[i].d, vecs[i].step);
            check($sformatf("wrap_vec%0d", i), 1'b0, vecs[i].eq, vecs[i].ef);
        end

        // Saturate-mode sequence from a fresh reset.
        @(negedge clk);
        rst = 1'b1; lo = 4'd3; hi = 4'd10;
        load = 0; en = 0; countup = 0; countdown = 0; clr_flags = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 4, 2);  check("sat_load4",     1'b1, 4'd4,  6'b000000);
        drive(0, 1, 0, 1, 0, 0, 2);  check("sat_dn_to_lo",  1'b1, 4'd3,  6'b010101);
        drive(0, 1, 0, 1, 0, 0, 2);  check("sat_dn_at_lo",  1'b1, 4'd3,  6'b010101);
        drive(0, 0, 0, 1, 0, 0, 2);  check("sat_hold",      1'b1, 4'd3,  6'b010001);
        drive(1, 0, 0, 0, 0, 9, 3);  check("sat_load9",     1'b1, 4'd9,  6'b000001);
        drive(0, 1, 1, 0, 0, 0, 3);  check("sat_up_to_hi",  1'b1, 4'd10, 6'b101011);
        drive(0, 1, 1, 0, 0, 0, 1);  check("sat_up_at_hi",  1'b1, 4'd10, 6'b101011);
        drive(0, 1, 1, 0, 0, 0, 0);  check("sat_step0",     1'b1, 4'd10, 6'b100011);

        // Asynchronous reset asserted between edges while counting.
        @(negedge clk);
        en = 1; countup = 1; step = 4'd1; load = 0; clr_flags = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_sat",  1'b1, 4'd5, 6'b000000);
        check("async_rst_wrap", 1'b0, 4'd5, 6'b000000);
        @(posedge clk);
        #1;
        check("rst_held", 1'b1, 4'd5, 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_count_after_rst", 1'b1, 4'd6, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
